uart_rx_core: RTL

Parametrised successor to the LD19 UART receiver. It takes the raw asynchronous serial line, synchronises it, and frames characters with configurable data width, parity and stop bits. Each bit is decided by a 3-sample majority vote at mid-bit. Received characters and their error flags are buffered in a small FIFO behind a valid/ready handshake. Packet-level consumers (header checking, error statistics) sit downstream of this block.

---
 rtl/uart_rx_core.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, 3-sample majority framing with
// configurable data/parity/stop, break detection and a small output FIFO.
module uart_rx_core #(
  parameter int unsigned CLK_DIV    = 52,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 armed
);

  localparam int unsigned TW  = $clog2(CLK_DIV);
  localparam int unsigned H   = CLK_DIV / 2;
  localparam int unsigned BW  = 4;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam logic        ODD = 1'(PARITY == 1);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 frame_err;
    logic                 parity_err;
  } entry_t;

  typedef enum logic [2:0] {
    S_ARM, S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;

  logic sync1, rxs, rxs_d;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n, arm_cnt, arm_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 smp0, smp0_n, smp1, smp1_n;
  logic                 any_one, any_one_n;
  logic                 frm_err, frm_err_n, par_err, par_err_n;
  logic                 armed_n, break_det_n;
  logic                 decide, maj;
  logic                 wr_en;
  entry_t               wr_entry;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head_n;
  logic          full, pop, push;

  // Line synchroniser; rxs_d gives the previous synchronised level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign decide = (timer == TW'(H + 1));
  assign maj    = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ARM;
      timer     <= '0;
      arm_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      smp0      <= 1'b1;
      smp1      <= 1'b1;
      any_one   <= 1'b0;
      frm_err   <= 1'b0;
      par_err   <= 1'b0;
      armed     <= 1'b0;
      break_det <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      arm_cnt   <= arm_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      smp0      <= smp0_n;
      smp1      <= smp1_n;
      any_one   <= any_one_n;
      frm_err   <= frm_err_n;
      par_err   <= par_err_n;
      armed     <= armed_n;
      break_det <= break_det_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    arm_cnt_n   = arm_cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    smp0_n      = smp0;
    smp1_n      = smp1;
    any_one_n   = any_one;
    frm_err_n   = frm_err;
    par_err_n   = par_err;
    armed_n     = armed;
    break_det_n = break_det;
    wr_en       = 1'b0;
    wr_entry    = '0;

    if (state inside {S_START, S_DATA, S_PAR, S_STOP}) begin
      timer_n = (timer == TW'(CLK_DIV - 1)) ? '0 : timer + TW'(1);
      if (timer == TW'(H - 1)) smp0_n = rxs;
      if (timer == TW'(H))     smp1_n = rxs;
    end

    case (state)
      S_ARM: begin
        if (!rxs) begin
          arm_cnt_n = '0;
        end else if (arm_cnt == TW'(CLK_DIV - 1)) begin
          arm_cnt_n = '0;
          armed_n   = 1'b1;
          state_n   = S_IDLE;
        end else begin
          arm_cnt_n = arm_cnt + TW'(1);
        end
      end
      // The edge cycle itself counts as timer 0
      S_IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = S_START;
          timer_n = TW'(1);
        end
      end
      S_START: begin
        if (decide) begin
          if (maj) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
            any_one_n = 1'b0;
            frm_err_n = 1'b0;
            par_err_n = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shreg_n   = {maj, shreg[DATA_BITS-1:1]};
          any_one_n = any_one | maj;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      S_PAR: begin
        if (decide) begin
          par_err_n = ((^shreg) ^ maj) != ODD;
          any_one_n = any_one | maj;
          state_n   = S_STOP;
        end
      end
      // Return to IDLE mid stop bit so the next falling edge resyncs the frame
      S_STOP: begin
        if (decide) begin
          frm_err_n = frm_err | !maj;
          any_one_n = any_one | maj;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_cnt_n = '0;
            if (!(any_one | maj)) begin
              state_n     = S_BRK;
              break_det_n = 1'b1;
            end else begin
              state_n             = S_IDLE;
              wr_en               = 1'b1;
              wr_entry.data       = shreg;
              wr_entry.frame_err  = frm_err | !maj;
              wr_entry.parity_err = par_err;
            end
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      S_BRK: begin
        if (rxs) begin
          state_n     = S_IDLE;
          break_det_n = 1'b0;
        end
      end
      default: state_n = S_ARM;
    endcase
  end

  // FIFO control; the head register is loaded with the entry that will be at rd_ptr next
  always_comb begin
    pop      = m_valid & m_ready;
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push     = wr_en && (!full || pop);
    rd_ptr_n = rd_ptr + PW'(pop);
    wr_ptr_n = wr_ptr + PW'(push);
    head_n   = (push && (rd_ptr_n == wr_ptr)) ? wr_entry : mem[rd_ptr_n[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_frame_err  <= 1'b0;
      m_parity_err <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      m_valid <= (rd_ptr_n != wr_ptr_n);
      overrun <= wr_en && full && !pop;
      if (rd_ptr_n != wr_ptr_n) begin
        m_data       <= head_n.data;
        m_frame_err  <= head_n.frame_err;
        m_parity_err <= head_n.parity_err;
      end
    end
  end

endmodule
